// File: rtl/dem_tree_recombiner.sv
// rtl/dem_tree_recombiner.sv - rebuilds the DEM tree sample from its 8 element streams and checks it against queued references
module dem_tree_recombiner #(
  parameter int INPUT_WIDTH = 16,
  parameter int REF_DEPTH   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            ref_valid_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_ref_i,
  input  logic                            valid_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_1_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_2_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_3_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_4_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_5_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_6_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_7_i,
  input  logic signed [INPUT_WIDTH-1:0]   x_in3_8_i,
  input  logic                            clear_i,
  output logic signed [INPUT_WIDTH+2:0]   y_o,
  output logic                            y_valid_o,
  output logic                            match_o,
  output logic [CNT_WIDTH-1:0]            mismatch_cnt_o,
  output logic [2:0]                      layer_status_o,
  output logic [$clog2(REF_DEPTH):0]      ref_level_o,
  output logic                            overflow_o,
  output logic                            underflow_o,
  output logic                            error_flag_o
);

  localparam int W  = INPUT_WIDTH;
  localparam int AW = $clog2(REF_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(REF_DEPTH);

  logic signed [W:0]   p1, p2, p3, p4;
  logic signed [W+1:0] q1, q2;
  logic                v1, v2;
  logic signed [W+2:0] y_sum;

  logic [W-1:0] mem [REF_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, level;
  logic [W-1:0] head;
  logic [W+2:0] head_ext;
  logic         fifo_empty, fifo_full, do_pop, do_push, ref_eq;

  assign y_sum = {q1[W+1], q1} + {q2[W+1], q2};

  // The extra pointer bit distinguishes full from empty when the indices coincide.
  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign do_pop     = v2 && !fifo_empty;
  assign do_push    = ref_valid_i && (!fifo_full || do_pop);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_ext   = {{3{head[W-1]}}, head};
  assign ref_eq     = ($unsigned(y_sum) == head_ext);

  // Reference storage; a push into the slot being popped reads the old value first.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= x_ref_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      y_valid_o      <= 1'b0;
      p1             <= '0;
      p2             <= '0;
      p3             <= '0;
      p4             <= '0;
      q1             <= '0;
      q2             <= '0;
      y_o            <= '0;
      match_o        <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mismatch_cnt_o <= '0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      v1        <= valid_i;
      v2        <= v1;
      y_valid_o <= v2;

      if (valid_i) begin
        p1 <= {x_in3_1_i[W-1], x_in3_1_i} + {x_in3_2_i[W-1], x_in3_2_i};
        p2 <= {x_in3_3_i[W-1], x_in3_3_i} + {x_in3_4_i[W-1], x_in3_4_i};
        p3 <= {x_in3_5_i[W-1], x_in3_5_i} + {x_in3_6_i[W-1], x_in3_6_i};
        p4 <= {x_in3_7_i[W-1], x_in3_7_i} + {x_in3_8_i[W-1], x_in3_8_i};
      end
      if (v1) begin
        q1 <= {p1[W], p1} + {p2[W], p2};
        q2 <= {p3[W], p3} + {p4[W], p4};
      end
      if (v2) begin
        y_o     <= y_sum;
        match_o <= do_pop && ref_eq;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

      // Clear takes priority over any event landing on the same edge.
      if (clear_i) begin
        mismatch_cnt_o <= '0;
        overflow_o     <= 1'b0;
        underflow_o    <= 1'b0;
      end else begin
        if (ref_valid_i && fifo_full && !do_pop) overflow_o <= 1'b1;
        if (v2 && fifo_empty) underflow_o <= 1'b1;
        if (do_pop && !ref_eq && !(&mismatch_cnt_o))
          mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
      end
    end
  end

  assign layer_status_o = {y_valid_o, v2, v1};
  assign ref_level_o    = level;
  assign error_flag_o   = (|mismatch_cnt_o) || overflow_o || underflow_o;

endmodule

// File: tb/tb_dem_tree_recombiner.sv
// tb/tb_dem_tree_recombiner.sv - self-checking bench for dem_tree_recombiner
module tb_dem_tree_recombiner;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_i, ref_valid_i, valid_i, clear_i;
  logic signed [W-1:0] x_ref_i;
  logic signed [W-1:0] el [8];
  logic signed [W+2:0] y_o;
  logic                y_valid_o, match_o, overflow_o, underflow_o, error_flag_o;
  logic [CW-1:0]       mismatch_cnt_o;
  logic [2:0]          layer_status_o;
  logic [$clog2(D):0]  ref_level_o;

  dem_tree_recombiner #(.INPUT_WIDTH(W), .REF_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .ref_valid_i(ref_valid_i), .x_ref_i(x_ref_i),
    .valid_i(valid_i),
    .x_in3_1_i(el[0]), .x_in3_2_i(el[1]), .x_in3_3_i(el[2]), .x_in3_4_i(el[3]),
    .x_in3_5_i(el[4]), .x_in3_6_i(el[5]), .x_in3_7_i(el[6]), .x_in3_8_i(el[7]),
    .clear_i(clear_i), .y_o(y_o), .y_valid_o(y_valid_o), .match_o(match_o),
    .mismatch_cnt_o(mismatch_cnt_o), .layer_status_o(layer_status_o),
    .ref_level_o(ref_level_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .error_flag_o(error_flag_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: refs wait in a bounded queue, samples emerge two edges after the edge that took them.
  typedef struct { longint sum; int due; } pend_t;
  int     ref_q[$];
  pend_t  pend[$];
  int     edge_n;
  int     hist[$];
  longint m_y;
  logic   m_yv, m_match, m_ovf, m_unf;
  int     m_cnt;

  task automatic model_reset();
    ref_q.delete(); pend.delete(); hist.delete();
    edge_n = 0; m_y = 0; m_yv = 0; m_match = 0; m_ovf = 0; m_unf = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic v, input longint sum, input logic rv, input int rval, input logic clr);
    pend_t it;
    int    r;
    logic  mism, ovf_e, unf_e;
    edge_n++;
    m_yv = 0; mism = 0; ovf_e = 0; unf_e = 0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      it = pend.pop_front();
      m_yv = 1; m_y = it.sum;
      if (ref_q.size() == 0) begin
        m_match = 0; unf_e = 1;
      end else begin
        r = ref_q.pop_front();
        m_match = (longint'(r) == it.sum);
        mism = !m_match;
      end
    end
    if (rv) begin
      if (ref_q.size() < D) ref_q.push_back(rval);
      else ovf_e = 1;
    end
    if (v) pend.push_back('{sum, edge_n + 2});
    hist.push_front(int'(v));
    if (hist.size() > 3) void'(hist.pop_back());
    if (clr) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (mism && m_cnt < (1 << CW) - 1) m_cnt++;
      if (ovf_e) m_ovf = 1;
      if (unf_e) m_unf = 1;
    end
  endtask

  function automatic int model_layers();
    int s = 0;
    for (int k = 0; k < hist.size(); k++) if (hist[k] != 0) s |= (1 << k);
    return s;
  endfunction

  task automatic compare_all();
    check("y_valid", y_valid_o, m_yv);
    if (m_yv) begin
      check("y", y_o, m_y);
      check("match", match_o, m_match);
    end
    check("mismatch_cnt", mismatch_cnt_o, m_cnt);
    check("overflow", overflow_o, m_ovf);
    check("underflow", underflow_o, m_unf);
    check("error_flag", error_flag_o, (m_cnt != 0) || m_ovf || m_unf);
    check("ref_level", ref_level_o, ref_q.size());
    check("layer_status", layer_status_o, model_layers());
  endtask

  task automatic step(input logic v, input logic rv, input int rval, input logic clr);
    longint sum = 0;
    valid_i = v; ref_valid_i = rv; x_ref_i = 16'(rval); clear_i = clr;
    for (int i = 0; i < 8; i++) sum += longint'(el[i]);
    @(posedge clk);
    model_edge(v, sum, rv, rval, clr);
    #1;
    compare_all();
  endtask

  task automatic set_fill(input int base, input int inc);
    for (int i = 0; i < 8; i++) el[i] = 16'(base + i * inc);
  endtask

  // Spread x over eight in-range elements, then shuffle value between random pairs.
  task automatic set_split(input int x);
    int e[8];
    int q, r, a, b, d;
    q = x >>> 3;
    r = x - 8 * q;
    for (int i = 0; i < 8; i++) e[i] = q + ((i < r) ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7)); d = int'($urandom_range(0, 3000));
      if (a != b && e[a] + d <= 32767 && e[b] - d >= -32768) begin
        e[a] += d; e[b] -= d;
      end
    end
    for (int i = 0; i < 8; i++) el[i] = 16'(e[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_y"}, y_o, 0);
    check({tag, "_y_valid"}, y_valid_o, 0);
    check({tag, "_match"}, match_o, 0);
    check({tag, "_cnt"}, mismatch_cnt_o, 0);
    check({tag, "_layers"}, layer_status_o, 0);
    check({tag, "_level"}, ref_level_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
    check({tag, "_underflow"}, underflow_o, 0);
    check({tag, "_error"}, error_flag_o, 0);
  endtask

  typedef struct { int base; int inc; int refv; longint exp_y; logic exp_m; } vec_t;

  initial begin
    vec_t tv[7];
    int   vals[24];
    int   rvs[5];
    int   lat, nyv, first_y, last_y, maxlvl, steady, cnt_before, want[$], n;
    logic v, rv;
    int   rval;

    tv[0] = '{4095, 0, 32760, 32760, 1'b1};
    tv[1] = '{-4096, 0, -32768, -32768, 1'b1};
    tv[2] = '{32767, 0, 32767, 262136, 1'b0};
    tv[3] = '{-32768, 0, -32768, -262144, 1'b0};
    tv[4] = '{1, 1, 36, 36, 1'b1};
    tv[5] = '{-3, -100, -2824, -2824, 1'b1};
    tv[6] = '{0, 0, 5, 0, 1'b0};

    // Reset held with traffic on the inputs
    reset_i = 1'b0; valid_i = 1'b1; ref_valid_i = 1'b1; x_ref_i = 16'sd5; clear_i = 1'b0;
    set_fill(100, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_i = 1'b1; valid_i = 1'b0; ref_valid_i = 1'b0;
    model_reset();

    // First sample and latency
    step(0, 1, 25000, 0);
    set_split(25000);
    step(1, 0, 0, 0);
    lat = 1;
    while (!y_valid_o && lat < 10) begin
      step(0, 0, 0, 0);
      lat++;
    end
    check("latency", lat, 3);
    check("first_y", y_o, 25000);
    check("first_match", match_o, 1);

    // Table vectors: extremes and patterns
    foreach (tv[k]) begin
      step(0, 1, tv[k].refv, 0);
      set_fill(tv[k].base, tv[k].inc);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check($sformatf("vec%0d_y", k), y_o, tv[k].exp_y);
      check($sformatf("vec%0d_match", k), match_o, tv[k].exp_m);
    end
    check("vec_cnt", mismatch_cnt_o, 3);
    check("vec_error", error_flag_o, 1);
    step(0, 0, 0, 1);

    // Back-to-back stream, each ref one edge ahead of its element group
    vals[0] = 32767; vals[1] = -32768; vals[2] = 16384;
    for (int i = 3; i < 22; i++) vals[i] = int'($urandom_range(0, 65535)) - 32768;
    vals[22] = 1; vals[23] = 0;
    nyv = 0; first_y = -1; last_y = -1; maxlvl = 0; steady = 0;
    for (int i = 0; i < 29; i++) begin
      v = (i >= 1 && i <= 24);
      if (v) set_split(vals[i-1]);
      step(v, i < 24, (i < 24) ? vals[i] : 0, 0);
      if (y_valid_o) begin
        nyv++;
        if (first_y < 0) first_y = i;
        last_y = i;
      end
      if (int'(ref_level_o) > maxlvl) maxlvl = int'(ref_level_o);
      if (layer_status_o == 3'b111) steady++;
    end
    check("b2b_count", nyv, 24);
    check("b2b_contiguous", last_y - first_y, 23);
    check("b2b_level_le3", maxlvl <= 3, 1);
    check("b2b_steady", steady, 22);
    check("b2b_cnt", mismatch_cnt_o, 0);

    // FIFO full then empty
    for (int k = 0; k < 5; k++) begin
      rvs[k] = int'($urandom_range(0, 65535)) - 32768;
      step(0, 1, rvs[k], 0);
    end
    check("full_level", ref_level_o, 4);
    check("full_overflow", overflow_o, 1);
    cnt_before = int'(mismatch_cnt_o);
    for (int k = 0; k < 5; k++) begin
      set_split(rvs[k]);
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("empty_underflow", underflow_o, 1);
    check("empty_match", match_o, 0);
    check("empty_cnt", mismatch_cnt_o, cnt_before);
    step(0, 0, 0, 1);

    // Push and pop together while full
    for (int k = 0; k < 4; k++) step(0, 1, rvs[k], 0);
    set_split(rvs[0]);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 777, 0);
    check("pushpop_overflow", overflow_o, 0);
    check("pushpop_level", ref_level_o, 4);
    check("pushpop_match", match_o, 1);

    // Mid-operation reset with two samples in flight and two refs queued
    reset_i = 1'b0;
    #1;
    reset_i = 1'b1;
    model_reset();
    step(0, 1, 1234, 0);
    step(0, 1, -77, 0);
    set_split(1234);
    step(1, 0, 0, 0);
    set_split(-77);
    step(1, 0, 0, 0);
    check("pre_reset_level", ref_level_o, 2);
    check("pre_reset_layers", layer_status_o, 3);
    #2;
    reset_i = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    model_reset();
    nyv = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      if (y_valid_o) nyv++;
    end
    check("no_stale_valid", nyv, 0);

    // Randomized traffic against the model
    want.delete();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      rval = int'($urandom_range(0, 65535)) - 32768;
      if (rv) want.push_back(rval);
      if (v) begin
        if (want.size() > 0 && $urandom_range(0, 3) != 0) set_split(want.pop_front());
        else for (int k = 0; k < 8; k++) el[k] = 16'($urandom_range(0, 65535));
      end
      step(v, rv, rval, $urandom_range(0, 49) == 0);
    end

    // Counter saturation, then clear colliding with a mismatch
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    set_fill(0, 0);
    el[0] = 16'sd1;
    n = 0;
    while (m_cnt < 65535 && n < 70000) begin
      step(1, 1, 0, 0);
      n++;
    end
    check("sat_reached", n < 70000, 1);
    repeat (3) step(1, 1, 0, 0);
    check("sat_cnt", mismatch_cnt_o, 16'hFFFF);
    step(1, 1, 0, 1);
    check("clear_y_valid", y_valid_o, 1);
    check("clear_cnt", mismatch_cnt_o, 0);
    check("clear_overflow", overflow_o, 0);
    check("clear_underflow", underflow_o, 0);
    check("clear_error", error_flag_o, 0);
    repeat (3) step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
